clk_div_gen: RTL and testbench



---
 rtl/clk_div_gen_if.sv | 25 ++
 rtl/clk_div_gen.sv | 96 +++++++++
 tb/tb_clk_div_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - control and status bundle for the clk_div_gen divider
interface clk_div_gen_if #(
  parameter int N = 8
);
  logic         en;
  logic         load;
  logic [N-1:0] m_in;
  logic         sync_clr;
  logic [N-1:0] q;
  logic         max_tick;
  logic         div_clk;
  logic         rise_tick;
  logic         fall_tick;
  logic         mid_tick;

  modport master (
    output en, load, m_in, sync_clr,
    input  q, max_tick, div_clk, rise_tick, fall_tick, mid_tick
  );

  modport slave (
    input  en, load, m_in, sync_clr,
    output q, max_tick, div_clk, rise_tick, fall_tick, mid_tick
  );
endinterface

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - programmable mod-M clock-enable / divided-clock generator
// Optional half-period strobe: define CLK_DIV_MID_TICK_EN.
module clk_div_gen #(
  parameter int N         = 8,
  parameter int M_DEFAULT = 10
) (
  input  logic          clk,
  input  logic          reset,
  clk_div_gen_if.slave  bus
);
  logic [N-1:0] q;
  logic [N-1:0] m_act;
  logic [N-1:0] m_pend;
  logic         pend_v;
  logic         div_clk;
  logic         max_tick;
  logic         rise_tick;
  logic         fall_tick;
  logic [N-1:0] m_clamp;
  logic         wrap;

  assign m_clamp = (bus.m_in < N'(2)) ? N'(2) : bus.m_in;
  assign wrap    = bus.en && (q == m_act - N'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      q         <= '0;
      m_act     <= N'(M_DEFAULT);
      m_pend    <= N'(M_DEFAULT);
      pend_v    <= 1'b0;
      div_clk   <= 1'b0;
      max_tick  <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      max_tick  <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      if (bus.sync_clr) begin
        q       <= '0;
        div_clk <= 1'b0;
        pend_v  <= 1'b0;
        if (bus.load) begin
          m_act  <= m_clamp;
          m_pend <= m_clamp;
        end else if (pend_v) begin
          m_act <= m_pend;
        end
      end else begin
        if (bus.load) begin
          m_pend <= m_clamp;
          pend_v <= 1'b1;
        end
        if (wrap) begin
          q         <= '0;
          max_tick  <= 1'b1;
          div_clk   <= ~div_clk;
          rise_tick <= ~div_clk;
          fall_tick <= div_clk;
          // A load landing on the wrap edge beats any older pending modulus.
          if (bus.load) begin
            m_act  <= m_clamp;
            pend_v <= 1'b0;
          end else if (pend_v) begin
            m_act  <= m_pend;
            pend_v <= 1'b0;
          end
        end else if (bus.en) begin
          q <= q + N'(1);
        end
      end
    end
  end

`ifdef CLK_DIV_MID_TICK_EN
  logic mid_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      mid_tick <= 1'b0;
    end else begin
      mid_tick <= !bus.sync_clr && bus.en && !wrap && ((q + N'(1)) == (m_act >> 1));
    end
  end

  assign bus.mid_tick = mid_tick;
`else
  assign bus.mid_tick = 1'b0;
`endif

  assign bus.q         = q;
  assign bus.max_tick  = max_tick;
  assign bus.div_clk   = div_clk;
  assign bus.rise_tick = rise_tick;
  assign bus.fall_tick = fall_tick;
endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - scoreboard bench for clk_div_gen with N=4, M_DEFAULT=10
module tb_clk_div_gen;
  typedef struct packed {
    logic [3:0] q;
    logic       mx;
    logic       dv;
    logic       rs;
    logic       fl;
    logic       md;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   tq;
  logic td;
  exp_t sb[$];

  clk_div_gen_if #(.N(4)) bus ();

  clk_div_gen #(.N(4), .M_DEFAULT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic e, input logic l, input logic [3:0] mi, input logic c,
                     input exp_t x, input string tag);
    exp_t obs;
    exp_t want;
    bus.en       = e;
    bus.load     = l;
    bus.m_in     = mi;
    bus.sync_clr = c;
    sb.push_back(x);
    @(posedge clk);
    #1;
    obs  = '{q: bus.q, mx: bus.max_tick, dv: bus.div_clk, rs: bus.rise_tick,
             fl: bus.fall_tick, md: bus.mid_tick};
    want = sb.pop_front();
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed q/max/div/rise/fall/mid=%h required=%h", tag, obs, want);
    end
  endtask

  // Count n enabled edges at constant modulus m from (tq, td); optional load on edge ld_at.
  task automatic run(input int n, input int m, input int ld_at, input logic [3:0] mi,
                     input string tag);
    exp_t x;
    int   qq;
    int   w;
    for (int i = 1; i <= n; i++) begin
      qq   = (tq + i) % m;
      w    = (tq + i) / m;
      x.q  = 4'(qq);
      x.mx = (qq == 0);
      x.dv = td ^ w[0];
      x.rs = (qq == 0) && x.dv;
      x.fl = (qq == 0) && !x.dv;
`ifdef CLK_DIV_MID_TICK_EN
      x.md = (qq == m / 2);
`else
      x.md = 1'b0;
`endif
      cyc(1'b1, (i == ld_at), mi, 1'b0, x, tag);
    end
    w  = (tq + n) / m;
    tq = (tq + n) % m;
    td = td ^ w[0];
  endtask

  task automatic hold(input int n, input logic l, input logic [3:0] mi, input string tag);
    for (int i = 0; i < n; i++)
      cyc(1'b0, l && (i == 0), mi, 1'b0, '{q: 4'(tq), mx: 1'b0, dv: td, rs: 1'b0, fl: 1'b0, md: 1'b0}, tag);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    tq           = 0;
    td           = 1'b0;
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.m_in     = '0;
    bus.sync_clr = 1'b0;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'd0, 1'b0, '0, "reset");
    reset = 1'b0;

    run(44, 10, 0, 4'd0, "default_m10");
    run(6, 10, 1, 4'd3, "load3_finish_period");
    run(12, 3, 0, 4'd0, "period_m3");

    run(1, 3, 1, 4'd0, "load0");
    run(1, 3, 1, 4'd1, "load1");
    run(1, 3, 0, 4'd0, "wrap_to_clamp");
    run(8, 2, 0, 4'd0, "period_m2");

    run(1, 2, 0, 4'd0, "pre_wrap_load");
    run(1, 2, 1, 4'd10, "load_on_wrap");
    run(6, 10, 0, 4'd0, "to_q6");

    hold(5, 1'b1, 4'd4, "en_low_hold");
    run(4, 10, 0, 4'd0, "resume");
    run(4, 4, 1, 4'd10, "period_m4");

    run(7, 10, 1, 4'd5, "to_q7_pend5");
    cyc(1'b1, 1'b0, 4'd0, 1'b1, '0, "sync_clr");
    tq = 0;
    td = 1'b0;
    run(6, 5, 0, 4'd0, "after_clr_m5");
    run(1, 5, 1, 4'd3, "pend3_before_reset");

    reset = 1'b1;
    cyc(1'b1, 1'b0, 4'd0, 1'b0, '0, "reset_mid_period");
    reset = 1'b0;
    tq = 0;
    td = 1'b0;
    run(20, 10, 0, 4'd0, "post_reset_m10");

    run(3, 10, 0, 4'd0, "to_q3");
    cyc(1'b1, 1'b1, 4'd1, 1'b1, '0, "sync_clr_load1");
    tq = 0;
    td = 1'b0;
    run(8, 2, 0, 4'd0, "clr_load_m2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
